// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the read-side and write-side pointer blocks of the
// asynchronous FIFO: the default address width and the binary/Gray code
// conversion helpers. The helpers work on 32-bit vectors so that any pointer
// width up to 32 bits can use them; callers truncate the result to their own
// pointer width.
// ---------------------------------------------------------------------------
package fifo_pkg;

  // Default FIFO address width; pointers carry one extra wrap bit.
  localparam int ADDRSIZE_DEF = 4;

  // Binary to reflected Gray code.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray code to binary. Each binary bit is the XOR of all Gray bits at or
  // above its position, so one pass from the MSB downward is enough.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// ---------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary converter of parameterizable width.
// Ports:
//   i_gray : W-bit Gray-coded input
//   o_bin  : W-bit binary equivalent
// ---------------------------------------------------------------------------
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  always_comb begin
    o_bin        = '0;
    o_bin[W-1]   = i_gray[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      o_bin[i] = o_bin[i+1] ^ i_gray[i];
    end
  end

endmodule

// File: rtl/rptr_empty.sv
// ---------------------------------------------------------------------------
// rptr_empty
// Read-side pointer and status logic of an asynchronous FIFO. Keeps the
// binary read pointer, publishes its Gray-coded image to the write domain and
// derives empty / almost-empty / fill level from the synchronized write
// pointer. A read attempted while empty is dropped and latches a sticky
// underflow flag.
// Ports:
//   clk           : read-domain clock (only clock)
//   rst           : synchronous active-high reset
//   rinc          : read request for one entry
//   rq2_wptr      : Gray write pointer, already double-synchronized into clk
//   raddr         : RAM read address (low bits of the binary read pointer)
//   graycode_rptr : registered Gray read pointer to the write domain
//   rempty        : registered empty flag
//   raempty       : registered almost-empty flag (level <= AEMPTY_THRESH)
//   rcount        : registered fill level seen by the reader
//   rerr          : sticky underflow flag, cleared only by rst
// ---------------------------------------------------------------------------
module rptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE      = ADDRSIZE_DEF,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   graycode_rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rcount,
  output logic                rerr
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

  logic [PW-1:0] r_rbin;
  logic [PW-1:0] r_rgray;
  logic          r_rempty;
  logic          r_raempty;
  logic [PW-1:0] r_rcount;
  logic          r_rerr;

  logic          w_rd_ok;
  logic          w_underflow;
  logic [PW-1:0] w_rbinnext;
  logic [PW-1:0] w_rgraynext;
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_rcount_next;
  logic          w_rempty_next;
  logic          w_raempty_next;

  // Binary image of the synchronized write pointer, for the level count.
  gray2bin #(.W(PW)) u_wptr_g2b (
    .i_gray (rq2_wptr),
    .o_bin  (w_wbin)
  );

  // A read is only accepted while not empty; the registered flag is used, so
  // there is no combinational path from rinc to any output.
  assign w_rd_ok     = rinc & ~r_rempty;
  assign w_underflow = rinc &  r_rempty;

  // Pointer arithmetic wraps naturally at 2^PW.
  assign w_rbinnext  = r_rbin + PW'(w_rd_ok);
  assign w_rgraynext = PW'(bin2gray(32'(w_rbinnext)));

  // Status is evaluated against the next pointer and the current write
  // pointer, so a read and a write-pointer update in the same cycle are
  // both accounted for.
  assign w_rempty_next  = (w_rgraynext == rq2_wptr);
  assign w_rcount_next  = w_wbin - w_rbinnext;
  assign w_raempty_next = (w_rcount_next <= AE_TH);

  // ---- register stage: pointer, flags and level ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rbin    <= '0;
      r_rgray   <= '0;
      r_rempty  <= 1'b1;
      r_raempty <= 1'b1;
      r_rcount  <= '0;
      r_rerr    <= 1'b0;
    end else begin
      r_rbin    <= w_rbinnext;
      r_rgray   <= w_rgraynext;
      r_rempty  <= w_rempty_next;
      r_raempty <= w_raempty_next;
      r_rcount  <= w_rcount_next;
      r_rerr    <= r_rerr | w_underflow;
    end
  end

  assign raddr         = r_rbin[ADDRSIZE-1:0];
  assign graycode_rptr = r_rgray;
  assign rempty        = r_rempty;
  assign raempty       = r_raempty;
  assign rcount        = r_rcount;
  assign rerr          = r_rerr;

endmodule

// File: tb/tb_rptr_empty.sv
// ---------------------------------------------------------------------------
// tb_rptr_empty
// Directed self-checking bench for rptr_empty with ADDRSIZE=4 and
// AEMPTY_THRESH=2. Inputs change 1 ns after a rising edge, outputs are
// checked at that same point, i.e. well away from the active edge.
// ---------------------------------------------------------------------------
module tb_rptr_empty;

  logic       clk = 1'b0;
  logic       rst;
  logic       rinc;
  logic [4:0] rq2_wptr;
  logic [3:0] raddr;
  logic [4:0] graycode_rptr;
  logic       rempty;
  logic       raempty;
  logic [4:0] rcount;
  logic       rerr;

  int errors = 0;
  int checks = 0;

  rptr_empty #(.ADDRSIZE(4), .AEMPTY_THRESH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .raddr         (raddr),
    .graycode_rptr (graycode_rptr),
    .rempty        (rempty),
    .raempty       (raempty),
    .rcount        (rcount),
    .rerr          (rerr)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".raddr"},   32'(raddr),         32'd0);
    check({tag, ".gray"},    32'(graycode_rptr), 32'd0);
    check({tag, ".rempty"},  32'(rempty),        32'd1);
    check({tag, ".raempty"}, 32'(raempty),       32'd1);
    check({tag, ".rcount"},  32'(rcount),        32'd0);
    check({tag, ".rerr"},    32'(rerr),          32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; rinc = 1'b0; rq2_wptr = 5'b00000;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] prev_gray;
    logic [4:0] exp_bin;

    // Reset state
    do_reset();
    check_reset_vals("reset");

    // Fill to 3 then drain
    rq2_wptr = 5'b00010;
    tick();
    check("fill.rempty",  32'(rempty),  32'd0);
    check("fill.rcount",  32'(rcount),  32'd3);
    check("fill.raempty", 32'(raempty), 32'd0);
    rinc = 1'b1;
    tick();
    check("rd1.gray",    32'(graycode_rptr), 32'h01);
    check("rd1.raempty", 32'(raempty),       32'd1);
    check("rd1.rempty",  32'(rempty),        32'd0);
    check("rd1.rcount",  32'(rcount),        32'd2);
    tick();
    check("rd2.gray",   32'(graycode_rptr), 32'h03);
    check("rd2.rempty", 32'(rempty),        32'd0);
    tick();
    check("rd3.gray",   32'(graycode_rptr), 32'h02);
    check("rd3.rempty", 32'(rempty),        32'd1);
    check("rd3.raddr",  32'(raddr),         32'd3);
    check("rd3.rcount", 32'(rcount),        32'd0);
    check("rd3.rerr",   32'(rerr),          32'd0);
    rinc = 1'b0;

    // Underflow from a fresh reset
    do_reset();
    rinc = 1'b1;
    tick();
    check("uflow.raddr",  32'(raddr),         32'd0);
    check("uflow.gray",   32'(graycode_rptr), 32'd0);
    check("uflow.rerr",   32'(rerr),          32'd1);
    check("uflow.rempty", 32'(rempty),        32'd1);
    rinc = 1'b0;
    rq2_wptr = 5'b00001;
    tick(); tick(); tick();
    check("uflow.sticky", 32'(rerr), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("uflow.clear", 32'(rerr), 32'd0);

    // Wrap: advance rbin to 31, then read across the wrap to 0
    do_reset();
    rq2_wptr = g5(5'd16);
    tick();
    check("wrap.full_lvl", 32'(rcount), 32'd16);
    rinc = 1'b1;
    exp_bin = 5'd0;
    for (int i = 0; i < 16; i++) begin
      prev_gray = graycode_rptr;
      tick();
      exp_bin = exp_bin + 5'd1;
      check("wrap.onebit_a", 32'($countones(prev_gray ^ graycode_rptr)), 32'd1);
    end
    check("wrap.rbin16", 32'(graycode_rptr), 32'(g5(5'd16)));
    check("wrap.empty16", 32'(rempty), 32'd1);
    rinc = 1'b0;
    rq2_wptr = 5'b10000;  // gray(31)
    tick();
    check("wrap.cnt15", 32'(rcount), 32'd15);
    rinc = 1'b1;
    for (int i = 0; i < 15; i++) begin
      prev_gray = graycode_rptr;
      tick();
      exp_bin = exp_bin + 5'd1;
      check("wrap.onebit_b", 32'($countones(prev_gray ^ graycode_rptr)), 32'd1);
    end
    check("wrap.gray31",   32'(graycode_rptr), 32'h10);
    check("wrap.raddr31",  32'(raddr),         32'(exp_bin[3:0]));
    check("wrap.empty31",  32'(rempty),        32'd1);
    rinc = 1'b0;
    rq2_wptr = 5'b00000;
    tick();
    check("wrap.cnt1",    32'(rcount), 32'd1);
    check("wrap.nempty",  32'(rempty), 32'd0);
    rinc = 1'b1;
    prev_gray = graycode_rptr;
    tick();
    check("wrap.gray0",   32'(graycode_rptr), 32'h00);
    check("wrap.raddr0",  32'(raddr),         32'd0);
    check("wrap.empty0",  32'(rempty),        32'd1);
    check("wrap.onebit",  32'($countones(prev_gray ^ graycode_rptr)), 32'd1);
    check("wrap.noerr",   32'(rerr),          32'd0);
    rinc = 1'b0;

    // Full level
    do_reset();
    rq2_wptr = 5'b11000;
    tick();
    check("full.rcount",  32'(rcount),  32'd16);
    check("full.rempty",  32'(rempty),  32'd0);
    check("full.raempty", 32'(raempty), 32'd0);

    // Simultaneous read and write-pointer advance, then mid-operation reset
    do_reset();
    rq2_wptr = g5(5'd4);
    tick();
    rinc = 1'b1;
    tick(); tick(); tick();
    check("simul.pre_cnt", 32'(rcount), 32'd1);
    rq2_wptr = g5(5'd5);
    tick();
    check("simul.rempty", 32'(rempty), 32'd0);
    check("simul.rcount", 32'(rcount), 32'd1);
    check("simul.raddr",  32'(raddr),  32'd4);
    tick();
    check("simul.rbin5",  32'(raddr),  32'd5);
    check("simul.empty5", 32'(rempty), 32'd1);
    rq2_wptr = g5(5'd9);
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    rinc = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, giving the FIFO address width; pointers are ADDRSIZE+1 bits wide.
REQ-002 SHALL have parameter AEMPTY_THRESH, default 2, giving the almost-empty threshold in entries.
REQ-003 SHALL have port clk, input, 1, the read-domain clock; this is the block's only clock.
REQ-004 SHALL have port rst, input, 1, the reset, which is synchronous and active-high.
REQ-005 SHALL have port rinc, input, 1, the read request for one entry.
REQ-006 SHALL have port rq2_wptr, input, ADDRSIZE+1, the Gray-coded write pointer already double-synchronized into clk.
REQ-007 SHALL have port raddr, output, ADDRSIZE, the RAM read address.
REQ-008 SHALL have port graycode_rptr, output, ADDRSIZE+1, the registered Gray read pointer sent to the write-domain synchronizer.
REQ-009 SHALL have port rempty, output, 1, the registered empty flag.
REQ-010 SHALL have port raempty, output, 1, the registered almost-empty flag.
REQ-011 SHALL have port rcount, output, ADDRSIZE+1, the registered fill level as seen by the reader.
REQ-012 SHALL have port rerr, output, 1, the sticky underflow flag.

Function
REQ-013 SHALL hold the binary read pointer rbin (ADDRSIZE+1 bits); raddr = rbin[ADDRSIZE-1:0], driven directly from the register.
REQ-014 SHALL compute rbinnext = rbin + (rinc & ~rempty), modulo 2^(ADDRSIZE+1), so the pointer wraps from all-ones to 0.
REQ-015 SHALL compute rgraynext = (rbinnext >> 1) ^ rbinnext and register it into graycode_rptr on the same edge as rbin.
REQ-016 SHALL register rempty = (rgraynext == rq2_wptr), comparing all ADDRSIZE+1 bits including the MSB.
REQ-017 SHALL reflect an accepted read on raddr, graycode_rptr and rempty at the next clk edge (latency 1).
REQ-018 SHALL deassert rempty one edge after rq2_wptr differs from rgraynext.
REQ-019 SHALL register rcount = gray2bin(rq2_wptr) - rbinnext, modulo 2^(ADDRSIZE+1); the maximum legal value is 2^ADDRSIZE.
REQ-020 SHALL register raempty = (rcount_next <= AEMPTY_THRESH).
REQ-021 SHALL ignore rinc while rempty=1; in that case the pointer does not move and rerr is set to 1.
REQ-022 SHALL hold rerr at 1 until rst.
REQ-023 SHALL evaluate a simultaneous accepted read and rq2_wptr change against the new rq2_wptr in the same cycle; no event is lost.
REQ-024 SHALL change graycode_rptr by exactly one bit per accepted read, including across the wrap.

Reset
REQ-025 SHALL, on any clk edge with rst=1, set rbin=0, graycode_rptr=0, raddr=0, rempty=1, raempty=1, rcount=0 and rerr=0.
REQ-026 SHALL let rst override rinc and rq2_wptr in the same cycle, including when asserted mid-operation.

Structure
REQ-027 SHALL define the shared package fifo_pkg to contain the ADDRSIZE default, the bin2gray function and the gray2bin function, shared with the write-side block.
REQ-028 SHALL place Gray-to-binary conversion in one combinational sub-module, gray2bin, parameterized by width.
REQ-029 SHALL keep all state in a single clk always-block with no latches and no combinational paths from input to output.

Verification (ADDRSIZE=4, AEMPTY_THRESH=2)
REQ-030 SHALL check reset: rst=1 for 2 cycles -> raddr=0, graycode_rptr=5'b00000, rempty=1, raempty=1, rcount=0, rerr=0.
REQ-031 SHALL check fill then drain: rq2_wptr=5'b00010 (bin 3) -> next edge rempty=0, rcount=3, raempty=0; then rinc=1 for 3 cycles -> graycode_rptr steps 00001, 00011, 00010, raempty=1 after the 1st read, and rempty=1 after the 3rd read.
REQ-032 SHALL check underflow: empty with rinc=1 -> raddr stays 0, rerr=1 and stays 1 until rst.
REQ-033 SHALL check wrap: rbin=31 (graycode_rptr=5'b10000) with rq2_wptr=gray(0)=5'b00000 and rinc=1 -> rbin=0, graycode_rptr=5'b00000, rempty=1.
REQ-034 SHALL check full level: rbin=0 with rq2_wptr=5'b11000 (bin 16) -> rcount=16, rempty=0.
REQ-035 SHALL check simultaneous events and mid-reset: rcount=1 with rinc=1 while rq2_wptr advances by one -> rempty=0 and rcount=1; then at rbin=5, rst=1 with rinc=1 -> all outputs at reset values on the next edge.
